// File: rtl/mb_seq_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier.
package mb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One recoded Booth digit: magnitude selects (one/two) plus sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } digit_t;

  function automatic int mb_digits(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/mb_digit_recoder.sv
// Radix-4 Booth recoder: triplet {a[2i+1], a[2i], a[2i-1]} -> {neg, one, two}.
module mb_digit_recoder
  import mb_seq_pkg::*;
(
  input  logic [2:0] trip,
  output digit_t     dig
);

  always_comb begin
    dig.one = trip[1] ^ trip[0];
    dig.two = (trip == 3'b011) || (trip == 3'b100);
    // 111 is a zero digit, so it must not carry a sign.
    dig.neg = trip[2] & ~(trip[1] & trip[0]);
  end

endmodule

// File: rtl/mb_seq_multiplier.sv
// Iterative radix-4 Modified Booth multiplier, one digit per clock.
// Define MB_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier digits are all zero.
module mb_seq_multiplier
  import mb_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [1:0]     dbg_state
);

  localparam int D  = mb_digits(W);
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  // Handshake: start is sampled only in IDLE; busy covers RUN and DONE;
  // done pulses for the single DONE cycle, when product becomes valid.
  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [2*W-1:0]  acc;
  logic [IW-1:0]   idx;

  logic [W:0]      a_ext;
  logic [2:0]      trip;
  digit_t          dig;
  logic [W+1:0]    pp_mag;
  logic [W+1:0]    pp;
  logic [2*W-1:0]  pp_ext;
  logic [2*W-1:0]  acc_next;
  logic            last;
  logic            rest_zero;

  assign a_ext = {a_q, 1'b0};
  assign trip  = 3'(a_ext >> {idx, 1'b0});

  mb_digit_recoder u_rec (
    .trip (trip),
    .dig  (dig)
  );

  always_comb begin
    pp_mag = '0;
    if (dig.two)
      pp_mag = {b_q[W-1], b_q, 1'b0};
    else if (dig.one)
      pp_mag = {{2{b_q[W-1]}}, b_q};
    pp       = dig.neg ? (~pp_mag + 1'b1) : pp_mag;
    pp_ext   = {{(W-2){pp[W+1]}}, pp};
    acc_next = acc + (pp_ext << {idx, 1'b0});
    last     = (idx == IW'(D - 1));
  end

`ifdef MB_SEQ_EARLY_EXIT_EN
  logic [W-1:0] a_hi;
  // a[W-1:2i+1] all-equal means every remaining triplet is 000 or 111.
  always_comb begin
    a_hi      = $signed(a_q) >>> {idx, 1'b1};
    rest_zero = (a_hi == '0) || (a_hi == '1);
  end
`else
  assign rest_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (last || rest_zero) begin
            product <= acc_next;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            acc <= acc_next;
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
